// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI3 read arbiter.
// Round-robin arbitration is enabled by defining AXI_ARB_RR_EN.
package axi_arb_pkg;

    localparam int NUM_S = 2;
    localparam int ID_W  = 4;
    localparam int LEN_W = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    localparam logic S_ICACHE = 1'b0;
    localparam logic S_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    // Flags a beat that disagrees with the granted ARLEN.
    function automatic logic len_bad(
        input logic [LEN_W-1:0] beat,
        input logic [LEN_W-1:0] len,
        input logic             last
    );
        return last ? (beat != len) : (beat == len);
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI3 read address/data channel bundle used on every arbiter port.
// Same bundle for cache-side and bus-side ports; modports set direction.
interface axi_rd_arbiter_if
    import axi_arb_pkg::*;
();

    logic [ID_W-1:0]  arid;
    logic [AW-1:0]    araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arvalid;
    logic             arready;

    logic [ID_W-1:0]  rid;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_arbiter_grant.sv
// Two-way request to one-hot grant; data cache wins ties by default.
// With AXI_ARB_RR_EN the last-served slave yields the next tie.
module arb_grant
    import axi_arb_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [NUM_S-1:0] req,
    input  logic             done,
    input  logic             done_idx,
    output logic [NUM_S-1:0] gnt
);

`ifdef AXI_ARB_RR_EN
    logic last;

    // Reset value S0 as last served hands the first tie to the data cache.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= S_ICACHE;
        end else if (done) begin
            last <= done_idx;
        end
    end

    always_comb begin
        gnt = '0;
        if (&req) begin
            if (last == S_DCACHE) begin
                gnt[S_ICACHE] = 1'b1;
            end else begin
                gnt[S_DCACHE] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end
`else
    logic unused;
    assign unused = ^{clk, resetn, done, done_idx};

    always_comb begin
        gnt = '0;
        if (req[S_DCACHE]) begin
            gnt[S_DCACHE] = 1'b1;
        end else if (req[S_ICACHE]) begin
            gnt[S_ICACHE] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges icache/dcache AXI3 read traffic onto one bus master port.
// Build option AXI_ARB_RR_EN selects round-robin instead of fixed priority.
module axi_rd_arbiter
    import axi_arb_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    axi_rd_arbiter_if.slave  s0,
    axi_rd_arbiter_if.slave  s1,
    axi_rd_arbiter_if.master m,
    output logic      err_len
);

    state_t           state;
    logic             own;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] len;
    logic [NUM_S-1:0] req;
    logic [NUM_S-1:0] gnt;
    logic             ar_hs;
    logic             r_hs;
    logic             done;

    assign req   = {s1.arvalid, s0.arvalid};
    assign ar_hs = (state == ADDR) && m.arvalid && m.arready;
    assign r_hs  = (state == DATA) && m.rvalid && m.rready;
    assign done  = r_hs && m.rlast;

    arb_grant u_grant (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .done     (done),
        .done_idx (own),
        .gnt      (gnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            own     <= S_ICACHE;
            beat    <= '0;
            len     <= '0;
            err_len <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        own   <= gnt[S_DCACHE];
                        len   <= gnt[S_DCACHE] ? s1.arlen : s0.arlen;
                        beat  <= '0;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat <= beat + 1'b1;
                        if (len_bad(beat, len, m.rlast)) begin
                            err_len <= 1'b1;
                        end
                        // Only RLAST ends the burst, even after a length error.
                        if (m.rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m.arid     = '0;
        m.araddr   = '0;
        m.arlen    = '0;
        m.arsize   = '0;
        m.arburst  = '0;
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        s0.arready = 1'b0;
        s1.arready = 1'b0;
        s0.rid     = '0;
        s0.rdata   = '0;
        s0.rresp   = '0;
        s0.rlast   = 1'b0;
        s0.rvalid  = 1'b0;
        s1.rid     = '0;
        s1.rdata   = '0;
        s1.rresp   = '0;
        s1.rlast   = 1'b0;
        s1.rvalid  = 1'b0;

        unique case (state)
            ADDR: begin
                if (own == S_DCACHE) begin
                    m.arid     = s1.arid;
                    m.araddr   = s1.araddr;
                    m.arlen    = s1.arlen;
                    m.arsize   = s1.arsize;
                    m.arburst  = s1.arburst;
                    m.arvalid  = s1.arvalid;
                    s1.arready = m.arready;
                end else begin
                    m.arid     = s0.arid;
                    m.araddr   = s0.araddr;
                    m.arlen    = s0.arlen;
                    m.arsize   = s0.arsize;
                    m.arburst  = s0.arburst;
                    m.arvalid  = s0.arvalid;
                    s0.arready = m.arready;
                end
            end
            DATA: begin
                if (own == S_DCACHE) begin
                    m.rready  = s1.rready;
                    s1.rid    = m.rid;
                    s1.rdata  = m.rdata;
                    s1.rresp  = m.rresp;
                    s1.rlast  = m.rlast;
                    s1.rvalid = m.rvalid;
                end else begin
                    m.rready  = s0.rready;
                    s0.rid    = m.rid;
                    s0.rdata  = m.rdata;
                    s0.rresp  = m.rresp;
                    s0.rlast  = m.rlast;
                    s0.rvalid = m.rvalid;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
